// File: rtl/ps2_scancode_ctrl_if.sv
// Byte-in / event-out handshake bundle for the PS/2 scan-code sequencer.
// master: byte receiver + event consumer; slave: the sequencer.
interface ps2_scancode_ctrl_if;
  logic       BYTE_VALID;
  logic       BYTE_ERR;
  logic [7:0] BYTE;
  logic       EVT_READY;
  logic       EVT_VALID;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BREAK;

  modport master (
    output BYTE_VALID, BYTE_ERR, BYTE, EVT_READY,
    input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK
  );

  modport slave (
    input  BYTE_VALID, BYTE_ERR, BYTE, EVT_READY,
    output EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK
  );
endinterface

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0/E1 prefix sequences into single
// {ext, break, code} key events, queued in a first-word fall-through FIFO.
module ps2_scancode_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                          CLK,
  input  logic                          RST,
  ps2_scancode_ctrl_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic                          KBD_OK,
  output logic                          KBD_ERR,
  output logic [7:0]                    ERR_CNT,
  input  logic                          CLR_FLAGS,
  output logic [2:0]                    STATE
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GOT_E0   = 3'd1,
    S_GOT_F0   = 3'd2,
    S_GOT_E0F0 = 3'd3,
    S_SKIP_E1  = 3'd4
  } state_t;

  state_t        state, nxt_state;
  logic [2:0]    skip_cnt, nxt_skip;
  logic [TW-1:0] tmo_cnt;
  logic          push, err_inc, set_ok, set_err;
  logic [9:0]    push_evt;

  // Event encoding is {ext, break, code}.
  always_comb begin
    nxt_state = state;
    nxt_skip  = skip_cnt;
    push      = 1'b0;
    push_evt  = '0;
    err_inc   = 1'b0;
    set_ok    = 1'b0;
    set_err   = 1'b0;
    if (bus.BYTE_VALID) begin
      if (bus.BYTE_ERR) begin
        nxt_state = S_IDLE;
        err_inc   = 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            unique case (bus.BYTE)
              8'hE0: nxt_state = S_GOT_E0;
              8'hF0: nxt_state = S_GOT_F0;
              8'hE1: begin
                nxt_state = S_SKIP_E1;
                nxt_skip  = 3'd7;
              end
              8'hAA: set_ok  = 1'b1;
              8'hFC: set_err = 1'b1;
              8'h00, 8'hFF: err_inc = 1'b1;
              default: begin
                push     = 1'b1;
                push_evt = {2'b00, bus.BYTE};
              end
            endcase
          end
          S_GOT_E0: begin
            if (bus.BYTE == 8'hF0) begin
              nxt_state = S_GOT_E0F0;
            end else if (bus.BYTE != 8'hE0) begin
              push      = 1'b1;
              push_evt  = {2'b10, bus.BYTE};
              nxt_state = S_IDLE;
            end
          end
          S_GOT_F0: begin
            push      = 1'b1;
            push_evt  = {2'b01, bus.BYTE};
            nxt_state = S_IDLE;
          end
          S_GOT_E0F0: begin
            push      = 1'b1;
            push_evt  = {2'b11, bus.BYTE};
            nxt_state = S_IDLE;
          end
          S_SKIP_E1: begin
            nxt_skip = skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) begin
              push      = 1'b1;
              push_evt  = {2'b10, 8'h77};
              nxt_state = S_IDLE;
            end
          end
          default: nxt_state = S_IDLE;
        endcase
      end
    end else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
      nxt_state = S_IDLE;
      err_inc   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
      KBD_OK   <= 1'b0;
      KBD_ERR  <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      state    <= nxt_state;
      skip_cnt <= nxt_skip;
      tmo_cnt  <= (nxt_state == S_IDLE || bus.BYTE_VALID) ? '0 : tmo_cnt + 1'b1;
      KBD_OK   <= set_ok  | (KBD_OK  & ~CLR_FLAGS);
      KBD_ERR  <= set_err | (KBD_ERR & ~CLR_FLAGS);
      if (CLR_FLAGS)
        ERR_CNT <= {7'd0, err_inc};
      else if (err_inc && ERR_CNT != 8'hFF)
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  assign STATE = state;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [9:0]    head_q;
  logic          pop, full, wr_en;

  assign pop   = (count != '0) && bus.EVT_READY;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_ptr] <= push_evt;
  end

  // head_q keeps the last head visible once the FIFO drains.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_q   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (count != '0) head_q <= mem[rd_ptr];
      OVERFLOW <= (push && full && !pop) | (OVERFLOW & ~CLR_FLAGS);
    end
  end

  assign bus.EVT_VALID = (count != '0);
  assign {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE} =
    (count != '0) ? mem[rd_ptr] : head_q;
  assign FIFO_LEVEL = count;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for ps2_scancode_ctrl; expected events are queued as bytes
// are driven and compared when the DUT hands them over.
module tb_ps2_scancode_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 20;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLR_FLAGS;
  logic [3:0] FIFO_LEVEL;
  logic       OVERFLOW, KBD_OK, KBD_ERR;
  logic [7:0] ERR_CNT;
  logic [2:0] STATE;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q [$];

  ps2_scancode_ctrl_if bus ();

  ps2_scancode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .FIFO_LEVEL(FIFO_LEVEL),
    .OVERFLOW(OVERFLOW), .KBD_OK(KBD_OK), .KBD_ERR(KBD_ERR),
    .ERR_CNT(ERR_CNT), .CLR_FLAGS(CLR_FLAGS), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: an event is expected only if the modelled FIFO has room.
  task automatic expect_evt(input logic [9:0] e);
    int occ;
    occ = exp_q.size() - ((bus.EVT_READY && exp_q.size() > 0) ? 1 : 0);
    if (occ < int'(DEPTH)) exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    bus.BYTE       = b;
    bus.BYTE_ERR   = err;
    bus.BYTE_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.BYTE_VALID = 1'b0;
    bus.BYTE_ERR   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_flags();
    CLR_FLAGS = 1'b1;
    idle(1);
    CLR_FLAGS = 1'b0;
  endtask

  task automatic drain();
    bus.EVT_READY = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) break;
    end
    @(posedge CLK); #1;
    bus.EVT_READY = 1'b0;
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_level", FIFO_LEVEL, 0);
  endtask

  always @(negedge CLK) begin
    if (!RST && bus.EVT_VALID && bus.EVT_READY) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL evt_unexpected: observed %0h expected none",
               {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE});
      end
      if (exp_q.size() > 0)
        chk("evt", {22'd0, bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE}, {22'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic [7:0] e1seq [8];
    logic [7:0] c;
    e1seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    RST = 1'b1; CLR_FLAGS = 1'b0;
    bus.BYTE_VALID = 1'b0; bus.BYTE_ERR = 1'b0; bus.BYTE = '0; bus.EVT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_state", STATE, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_valid", bus.EVT_VALID, 0);
    chk("rst_flags", {OVERFLOW, KBD_OK, KBD_ERR}, 0);
    chk("rst_errcnt", ERR_CNT, 0);
    chk("rst_code", {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE}, 0);

    // Plain make code, one-cycle latency, then popped.
    expect_evt({2'b00, 8'h1C});
    send(8'h1C);
    chk("make_valid", bus.EVT_VALID, 1);
    chk("make_level", FIFO_LEVEL, 1);
    chk("make_head", {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE}, {2'b00, 8'h1C});
    bus.EVT_READY = 1'b1;
    idle(1);
    bus.EVT_READY = 1'b0;
    chk("make_pop_level", FIFO_LEVEL, 0);
    chk("make_pop_valid", bus.EVT_VALID, 0);

    // Extended break E0 F0 75.
    send(8'hE0);
    chk("e0_state", STATE, 1);
    send(8'hF0);
    chk("e0f0_state", STATE, 3);
    expect_evt({2'b11, 8'h75});
    send(8'h75);
    chk("e0f0_done_state", STATE, 0);
    chk("e0f0_level", FIFO_LEVEL, 1);
    drain();

    // Pause sequence collapses into one event.
    for (int i = 0; i < 7; i++) begin
      send(e1seq[i]);
      chk("pause_state", STATE, 4);
      chk("pause_level", FIFO_LEVEL, 0);
    end
    expect_evt({2'b10, 8'h77});
    send(e1seq[7]);
    chk("pause_done_state", STATE, 0);
    chk("pause_level_end", FIFO_LEVEL, 1);
    drain();

    // Nine pushes into an eight-deep FIFO: last dropped.
    for (int i = 0; i < 9; i++) begin
      c = 8'h15 + 8'(i);
      expect_evt({2'b00, c});
      send(c);
    end
    chk("ovf_level", FIFO_LEVEL, DEPTH);
    chk("ovf_flag", OVERFLOW, 1);
    drain();
    chk("ovf_sticky", OVERFLOW, 1);
    clear_flags();
    chk("ovf_clr", OVERFLOW, 0);

    // Full FIFO with a simultaneous pop accepts the push.
    for (int i = 0; i < 8; i++) begin
      c = 8'h21 + 8'(i);
      expect_evt({2'b00, c});
      send(c);
    end
    chk("full_level", FIFO_LEVEL, DEPTH);
    bus.EVT_READY = 1'b1;
    expect_evt({2'b00, 8'h29});
    send(8'h29);
    chk("full_pop_level", FIFO_LEVEL, DEPTH);
    chk("full_pop_noovf", OVERFLOW, 0);
    drain();

    // Prefix timeout.
    send(8'hF0);
    chk("tmo_state_f0", STATE, 2);
    idle(TMO - 1);
    chk("tmo_state_before", STATE, 2);
    chk("tmo_errcnt_before", ERR_CNT, 0);
    idle(1);
    chk("tmo_state_after", STATE, 0);
    chk("tmo_errcnt_after", ERR_CNT, 1);
    expect_evt({2'b00, 8'h1C});
    send(8'h1C);
    chk("tmo_next_head", {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE}, {2'b00, 8'h1C});
    drain();
    clear_flags();
    chk("tmo_clr", ERR_CNT, 0);

    // Byte errors, overrun code, clear-with-increment.
    send(8'hF0, 1'b1);
    chk("berr_state", STATE, 0);
    chk("berr_errcnt", ERR_CNT, 1);
    chk("berr_level", FIFO_LEVEL, 0);
    CLR_FLAGS = 1'b1;
    send(8'h33, 1'b1);
    CLR_FLAGS = 1'b0;
    chk("clr_inc_errcnt", ERR_CNT, 1);
    send(8'h00);
    chk("overrun_errcnt", ERR_CNT, 2);
    chk("overrun_level", FIFO_LEVEL, 0);
    clear_flags();
    chk("errcnt_clr", ERR_CNT, 0);

    // Self-test status codes.
    send(8'hAA);
    chk("kbd_ok", {KBD_OK, KBD_ERR}, 2'b10);
    chk("kbd_ok_nopush", bus.EVT_VALID, 0);
    send(8'hFC);
    chk("kbd_err", {KBD_OK, KBD_ERR}, 2'b11);
    clear_flags();
    chk("kbd_clr", {KBD_OK, KBD_ERR}, 2'b00);

    // Reset mid-sequence with events queued.
    send(8'h31);
    send(8'h32);
    send(8'h34);
    send(8'hE0);
    chk("pre_rst_state", STATE, 1);
    chk("pre_rst_level", FIFO_LEVEL, 3);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_level", FIFO_LEVEL, 0);
    chk("mid_rst_valid", bus.EVT_VALID, 0);
    chk("mid_rst_flags", {OVERFLOW, KBD_OK, KBD_ERR, ERR_CNT}, 0);
    chk("mid_rst_code", {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE}, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
Sequencer between the PS/2 byte receiver and the display/LED logic. It consumes validated scan-code bytes and tracks the E0, F0 and E1 prefix sequences. It turns each complete sequence into one key event {ext, break, code} and buffers the events in a small FIFO with a valid/ready handshake. It also tracks keyboard self-test status, byte errors and prefix timeouts.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
TIMEOUT, 1000000, CLK cycles allowed between bytes of one sequence (10 ms at 100 MHz).

Ports:
CLK  in  1  system clock; all logic on its rising edge.
RST  in  1  reset; synchronous, active-high.
BYTE_VALID  in  1  one-cycle pulse; a received byte is presented.
BYTE_ERR  in  1  qualifies BYTE_VALID; frame/parity error on this byte.
BYTE  in  8  received byte, valid only with BYTE_VALID.
EVT_READY  in  1  consumer accepts the head event.
EVT_VALID  out  1  FIFO non-empty.
EVT_CODE  out  8  head event scan code.
EVT_EXT  out  1  head event had E0 prefix (or is Pause).
EVT_BREAK  out  1  head event is a release.
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  entries stored.
OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
KBD_OK  out  1  sticky: AA received in IDLE.
KBD_ERR  out  1  sticky: FC received in IDLE.
ERR_CNT  out  8  saturating count of byte errors plus timeouts.
CLR_FLAGS  in  1  clears OVERFLOW, KBD_OK, KBD_ERR and ERR_CNT.
STATE  out  3  FSM state for LED debug: IDLE=0, GOT_E0=1, GOT_F0=2, GOT_E0F0=3, SKIP_E1=4.

Behaviour:
- Reset (sync, RST high at a CLK edge):
  - FSM goes to IDLE; FIFO empty; skip and timeout counters cleared.
  - Every output is 0.
  - RST mid-sequence discards the partial prefix.
- Byte accept: a byte is processed on any cycle with BYTE_VALID=1.
  - If BYTE_ERR=1, the byte is discarded, the FSM goes to IDLE and ERR_CNT increments (saturating at 255).
- IDLE transitions:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - E1 -> SKIP_E1 with skip count 7.
  - AA -> KBD_OK=1.
  - FC -> KBD_ERR=1.
  - 00 or FF (keyboard overrun) -> discarded, ERR_CNT+1.
  - Any other byte -> push {ext=0, brk=0, code}.
- GOT_E0: F0 -> GOT_E0F0; E0 -> stay and restart the timeout; any other byte -> push {1,0,byte}, then IDLE.
- GOT_F0: any byte -> push {0,1,byte}, then IDLE.
- GOT_E0F0: any byte -> push {1,1,byte}, then IDLE.
- SKIP_E1: each byte decrements the skip count. On the 7th byte, push {1,0,8'h77} (Pause) and go to IDLE.
- Timeout:
  - In any non-IDLE state, a counter runs and resets on each accepted byte.
  - If it reaches TIMEOUT-1 with no byte, the FSM goes to IDLE, ERR_CNT+1, and nothing is pushed.
  - In IDLE the counter is held at 0.
- FIFO:
  - First-word fall-through: EVT_* are driven from the head entry.
  - Pop on EVT_VALID && EVT_READY.
  - A push at edge n is visible at EVT_VALID/FIFO_LEVEL after edge n (one-cycle latency from BYTE_VALID).
  - Push while full with no pop: event dropped, OVERFLOW=1.
  - Push while full with a pop in the same cycle: accepted, level unchanged, no overflow.
  - Push and pop while non-full: level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - When EVT_VALID=0, EVT_CODE/EXT/BREAK hold their last values (don't-care for the consumer).
- CLR_FLAGS: if a set event for a flag occurs in the same cycle, the set wins. For ERR_CNT, CLR plus an increment in the same cycle gives 1.
- Data events are stored only in the FIFO; sticky flags do not enter the FIFO.

Test Plan:
- Byte 1C, then EVT_READY=1 -> EVT_VALID high one cycle after BYTE_VALID with {EXT=0, BREAK=0, CODE=1C}, then popped; FIFO_LEVEL returns to 0.
- Bytes E0 F0 75 with EVT_READY=0 -> exactly one event {1,1,75}; STATE steps 1, 3, 0; FIFO_LEVEL=1.
- E1 14 77 E1 F0 14 F0 77 -> a single event {1,0,77}; STATE=4 during the sequence; no other pushes.
- 9 make codes with EVT_READY=0 and FIFO_DEPTH=8 -> FIFO_LEVEL=8, OVERFLOW=1, the first 8 codes read out in order.
- Repeat the full-FIFO case with EVT_READY=1 on the 9th push -> OVERFLOW stays 0.
- F0, then TIMEOUT cycles idle, then 1C -> ERR_CNT=1, STATE back to 0, event {0,0,1C}.
- BYTE_ERR with F0 -> no state change from IDLE, ERR_CNT=1.
- Byte AA -> KBD_OK=1 and nothing pushed; byte FC -> KBD_ERR=1; CLR_FLAGS -> both clear.
- RST asserted while in GOT_E0 with 3 events queued -> next cycle STATE=0, FIFO_LEVEL=0, all flags 0.
